shift_out: RTL and testbench

- Parallel-in, serial-out transmitter. Takes an 8-bit word over a valid/ready handshake and drives it one bit per clock on a single serial line.
- It is the transmit end for the existing 8-stage serial-in capture register. A word sent here and clocked into that register appears there intact after the last bit.
- Sits between the datapath (word source) and any serial link or loopback path.

---
 rtl/shift_out_pkg.sv | 15 +
 rtl/shift_out_ctr.sv | 40 ++++
 rtl/shift_out.sv | 96 +++++++++
 tb/tb_shift_out.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_out_pkg.sv
// Shared types and helpers for the shift_out serial transmitter.
package shift_out_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_out_ctr.sv
// Bit-position counter for shift_out: clear has priority over enable,
// tc flags the final bit position (WIDTH-1).
module shift_out_ctr
  import shift_out_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_out.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready
// handshake and sends it LSB first, one bit per clock, back-to-back capable.
module shift_out
  import shift_out_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             shifting;
  logic             ctr_clr;
  logic             ctr_en;

  assign shifting   = (state_q == SHIFT);
  assign load_ready = (state_q == IDLE) || (shifting && tc);
  assign accept     = load_valid && load_ready && !rst;

  // Counter returns to 0 both on a fresh load and when the frame ends.
  assign ctr_clr = accept || (shifting && tc);
  assign ctr_en  = shifting && !tc;

  shift_out_ctr #(
    .WIDTH(WIDTH)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!tc) begin
          shreg_d = shreg_q >> 1;
        end else if (accept) begin
          shreg_d = data_in;
        end else begin
          shreg_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign out       = shifting && shreg_q[0];
  assign out_valid = shifting;
  assign busy      = shifting;
  assign last      = shifting && tc;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_shift_out.sv
// Directed bench for shift_out with an 8-stage serial-in receiver model
// on the serial line.
module tb_shift_out;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] data_in;
  logic       load_ready;
  logic       out;
  logic       out_valid;
  logic       last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q;

  shift_out #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .data_in    (data_in),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial-in capture register: shifts in at the MSB so bit 0 ends at the LSB.
  always @(posedge clk) begin
    if (out_valid) rx_q <= {out, rx_q[7:1]};
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;   // serial line in time order, seq[7] first
    logic [7:0] rx;    // receiver contents after the frame
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the WIDTH bit cycles of a frame already accepted; optionally
  // presents the next word during the last-bit cycle.
  task automatic run_bits(input string tag, input logic [7:0] seq,
                          input logic chain, input logic [7:0] next_word);
    for (int i = 0; i < 8; i++) begin
      chk({tag, " out"}, 32'(out), 32'(seq[7-i]));
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " last"}, 32'(last), (i == 7) ? 32'd1 : 32'd0);
      chk({tag, " load_ready"}, 32'(load_ready), (i == 7) ? 32'd1 : 32'd0);
      if (i == 7 && chain) begin
        load_valid = 1'b1;
        data_in    = next_word;
      end
      tick();
      load_valid = 1'b0;
      data_in    = 8'h00;
    end
  endtask

  task automatic start_word(input string tag, input logic [7:0] w);
    load_valid = 1'b1;
    data_in    = w;
    chk({tag, " ready_before"}, 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    data_in    = ~w;  // frame must not follow data_in after the accept edge
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle out"}, 32'(out), 32'd0);
    chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " idle last"}, 32'(last), 32'd0);
    chk({tag, " idle load_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, seq: 8'b1010_0101, rx: 8'hA5};
    vecs[1] = '{word: 8'h3C, seq: 8'b0011_1100, rx: 8'h3C};
    vecs[2] = '{word: 8'h00, seq: 8'b0000_0000, rx: 8'h00};
    vecs[3] = '{word: 8'hFF, seq: 8'b1111_1111, rx: 8'hFF};
    vecs[4] = '{word: 8'h81, seq: 8'b1000_0001, rx: 8'h81};
    vecs[5] = '{word: 8'hC8, seq: 8'b0001_0011, rx: 8'hC8};

    rst = 1'b1; load_valid = 1'b0; data_in = 8'h00; rx_q = 8'h55;
    tick(); tick();
    chk("reset out", 32'(out), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset last", 32'(last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Single frames with receiver loopback
    for (int v = 0; v < 6; v++) begin
      start_word($sformatf("vec%0d", v), vecs[v].word);
      run_bits($sformatf("vec%0d", v), vecs[v].seq, 1'b0, 8'h00);
      chk($sformatf("vec%0d rx", v), 32'(rx_q), 32'(vecs[v].rx));
      chk_idle($sformatf("vec%0d", v));
      tick();
    end
    $display("single frames done checks=%0d", checks);

    // Back-to-back 3C then C3: 16 contiguous valid cycles
    start_word("b2b0", 8'h3C);
    run_bits("b2b0", 8'b0011_1100, 1'b1, 8'hC3);
    chk("b2b rx first", 32'(rx_q), 32'h3C);
    run_bits("b2b1", 8'b1100_0011, 1'b0, 8'h00);
    chk("b2b rx second", 32'(rx_q), 32'hC3);
    chk_idle("b2b");
    $display("back-to-back done checks=%0d", checks);

    // Load attempts while busy are ignored until the last-bit cycle
    start_word("ign", 8'hFF);
    for (int i = 0; i < 8; i++) begin
      if (i >= 1) begin
        load_valid = 1'b1;
        data_in    = 8'h00;
      end
      chk("ign out", 32'(out), 32'd1);
      chk("ign last", 32'(last), (i == 7) ? 32'd1 : 32'd0);
      chk("ign load_ready", 32'(load_ready), (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    load_valid = 1'b0;
    chk("ign rx ff", 32'(rx_q), 32'hFF);
    run_bits("ign_next", 8'h00, 1'b0, 8'h00);
    chk("ign rx 00", 32'(rx_q), 32'h00);
    chk_idle("ign");
    $display("ignored-load done checks=%0d", checks);

    // Reset mid-frame after 3 bits of F0
    start_word("mid", 8'hF0);
    for (int i = 0; i < 3; i++) begin
      chk("mid out", 32'(out), 32'd0);
      chk("mid out_valid", 32'(out_valid), 32'd1);
      if (i == 2) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk_idle("mid");
    for (int i = 0; i < 10; i++) begin
      chk("mid no last", 32'(last), 32'd0);
      chk("mid no valid", 32'(out_valid), 32'd0);
      tick();
    end
    start_word("mid5a", 8'h5A);
    run_bits("mid5a", 8'b0101_1010, 1'b0, 8'h00);
    chk("mid5a rx", 32'(rx_q), 32'h5A);
    chk_idle("mid5a");
    $display("reset mid-frame done checks=%0d", checks);

    // Load presented only while reset is asserted
    rst = 1'b1; load_valid = 1'b1; data_in = 8'hAA;
    tick(); tick();
    chk("rstload out_valid during", 32'(out_valid), 32'd0);
    rst = 1'b0; load_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstload out_valid", 32'(out_valid), 32'd0);
      chk("rstload out", 32'(out), 32'd0);
    end
    $display("load-during-reset done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
